core_sequencer: RTL

CORE_SEQUENCER -- requirements
Module: core_sequencer

---
 rtl/core_sequencer_if.sv | 30 +++
 rtl/core_sequencer.sv | 80 ++++++++
 2 files changed

// File: rtl/core_sequencer_if.sv
// core_sequencer_if: control/handshake bundle between the sequencer and the fetch/decode/memory datapath
interface core_sequencer_if;
  logic        start;
  logic [6:0]  opcode;
  logic        next_PC_select;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req;
  logic        dmem_req;
  logic        dmem_we;
  logic        ir_wEn;
  logic        pc_wEn;
  logic        rf_wEn;
  logic        pc_sel;
  logic [2:0]  state;
  logic        halted;
  logic        illegal;
  logic [31:0] cycle_count;
  logic [31:0] instret;
  modport master (
    input  start, opcode, next_PC_select, imem_ready, dmem_ready,
    output imem_req, dmem_req, dmem_we, ir_wEn, pc_wEn, rf_wEn, pc_sel,
           state, halted, illegal, cycle_count, instret
  );
  modport slave (
    output start, opcode, next_PC_select, imem_ready, dmem_ready,
    input  imem_req, dmem_req, dmem_we, ir_wEn, pc_wEn, rf_wEn, pc_sel,
           state, halted, illegal, cycle_count, instret
  );
endinterface

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle FETCH/DECODE/EXECUTE/MEM/WB control FSM with sticky illegal flag and perf counters
module core_sequencer #(
  parameter int ADDRESS_BITS = 16
) (
  input  logic             clock,
  input  logic             reset,
  core_sequencer_if.master bus
);
  if (ADDRESS_BITS < 1) begin : g_addr_chk
    $error("ADDRESS_BITS must be positive");
  end
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, MEM, WB, HALT, BAD} state_t;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  state_t      state_q, state_d;
  logic [6:0]  opcode_q, opcode_d;
  logic        illegal_q, illegal_d;
  logic [31:0] cycle_count_q, cycle_count_d;
  logic [31:0] instret_q, instret_d;
  logic        legal;
  assign legal = bus.opcode inside {OP_ALU, OP_ALUI, OP_LOAD, OP_STORE, OP_BRANCH,
                                    OP_JAL, OP_JALR, OP_AUIPC, OP_LUI};
  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    illegal_d     = illegal_q;
    cycle_count_d = cycle_count_q + {31'b0, (state_q != IDLE) && (state_q != HALT)};
    instret_d     = instret_q + {31'b0, state_q == WB};
    unique case (state_q)
      IDLE:    state_d = bus.start ? FETCH : IDLE;
      FETCH:   state_d = bus.imem_ready ? DECODE : FETCH;
      DECODE: begin
        opcode_d  = bus.opcode;
        state_d   = legal ? EXECUTE : HALT;
        illegal_d = illegal_q | (!legal && bus.opcode != OP_SYSTEM);
      end
      EXECUTE: state_d = (opcode_q == OP_LOAD || opcode_q == OP_STORE) ? MEM : WB;
      MEM:     state_d = bus.dmem_ready ? WB : MEM;
      WB:      state_d = FETCH;
      HALT:    state_d = HALT;
      BAD:     state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      opcode_q      <= '0;
      illegal_q     <= 1'b0;
      cycle_count_q <= '0;
      instret_q     <= '0;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      illegal_q     <= illegal_d;
      cycle_count_q <= cycle_count_d;
      instret_q     <= instret_d;
    end
  end
  // Strobes, state and halted are held at zero while reset is asserted, even before the edge lands.
  assign bus.imem_req    = reset && state_q == FETCH;
  assign bus.ir_wEn      = bus.imem_req && bus.imem_ready;
  assign bus.dmem_req    = reset && state_q == MEM;
  assign bus.dmem_we     = bus.dmem_req && opcode_q == OP_STORE;
  assign bus.pc_wEn      = reset && state_q == WB;
  assign bus.pc_sel      = bus.pc_wEn && bus.next_PC_select;
  assign bus.rf_wEn      = bus.pc_wEn && opcode_q != OP_STORE && opcode_q != OP_BRANCH;
  assign bus.state       = reset ? state_q : IDLE;
  assign bus.halted      = reset && state_q == HALT;
  assign bus.illegal     = illegal_q;
  assign bus.cycle_count = cycle_count_q;
  assign bus.instret     = instret_q;
endmodule
